// File: rtl/ldpc_info_source.sv
// ldpc_info_source: framed information-bit source feeding the QC-LDPC encoder.
// Emits frames of kb sub-blocks (Z bits each) over valid/ready, with sof/eof,
// a programmable inter-frame gap, a frame count and a PRBS-23 or counter payload.
// The startup cycle reuses the GAP state with a zero count, so the first beat
// is presented one cycle after start is sampled.
module ldpc_info_source #(
  parameter int          Z      = 27,
  parameter int          KB_MAX = 18,
  parameter logic [22:0] SEED   = 23'h7FFFFF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic [4:0]   kb,
  input  logic [15:0]  num_frames,
  input  logic [7:0]   gap,
  input  logic         mode,
  input  logic         ready,
  output logic [Z-1:0] data_out,
  output logic         valid,
  output logic         sof,
  output logic         eof,
  output logic         busy,
  output logic [15:0]  frame_cnt,
  output logic         done
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, GAP = 2'd2} state_t;

  localparam logic [22:0] SEED_EFF = (SEED == 23'd0) ? 23'd1 : SEED;
  localparam logic [4:0]  KB_LIM   = 5'(KB_MAX);

  // Z output bits of the x^23+x^18+1 generator; bit 0 is generated first.
  function automatic logic [Z-1:0] prbs_bits(input logic [22:0] s);
    logic [22:0]  t;
    logic         fb;
    logic [Z-1:0] b;
    t = s;
    b = '0;
    for (int i = 0; i < Z; i++) begin
      fb   = t[22] ^ t[17];
      b[i] = fb;
      t    = {t[21:0], fb};
    end
    return b;
  endfunction

  // Generator state after Z steps.
  function automatic logic [22:0] prbs_next(input logic [22:0] s);
    logic [22:0] t;
    logic        fb;
    t = s;
    for (int i = 0; i < Z; i++) begin
      fb = t[22] ^ t[17];
      t  = {t[21:0], fb};
    end
    return t;
  endfunction

  state_t      state, state_nxt;
  logic [22:0] lfsr, lfsr_d;
  logic [Z-1:0] cnt, cnt_d, data_d;
  logic [4:0]  idx, idx_d, kb_r, kb_d, nidx, kb_clamp;
  logic [15:0] nf_r, nf_d, fc_d, fc_inc;
  logic [7:0]  gap_r, gap_d, gap_cnt, gap_cnt_d;
  logic        mode_r, mode_d, stop_pend, stop_pend_d;
  logic        valid_d, sof_d, eof_d, busy_d, done_d;
  logic        accept, last_beat, run_end, load, launch;

  assign accept    = valid & ready;
  assign last_beat = accept & eof;
  assign fc_inc    = (frame_cnt == 16'hFFFF) ? frame_cnt : frame_cnt + 16'd1;
  assign run_end   = last_beat &
                     (((nf_r != 16'd0) && (fc_inc == nf_r)) || stop_pend || stop);
  assign kb_clamp  = (kb > KB_LIM) ? KB_LIM : kb;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start && (kb != 5'd0)) state_nxt = GAP;
        else                       state_nxt = IDLE;
      end
      RUN: begin
        if (run_end)                              state_nxt = IDLE;
        else if (last_beat && (gap_r != 8'd0))    state_nxt = GAP;
        else                                      state_nxt = RUN;
      end
      GAP: begin
        if (stop)                   state_nxt = IDLE;
        else if (gap_cnt == 8'd0)   state_nxt = RUN;
        else                        state_nxt = GAP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the datapath and registered outputs.
  always_comb begin
    launch      = (state == IDLE) && (state_nxt == GAP);
    load        = ((state == RUN) && accept && (state_nxt == RUN)) ||
                  ((state == GAP) && (state_nxt == RUN));
    nidx        = ((state == RUN) && !eof) ? idx + 5'd1 : 5'd0;
    valid_d     = (state_nxt == RUN);
    busy_d      = (state_nxt != IDLE);
    done_d      = (state != IDLE) && (state_nxt == IDLE);
    lfsr_d      = lfsr;
    cnt_d       = cnt;
    idx_d       = idx;
    kb_d        = kb_r;
    nf_d        = nf_r;
    gap_d       = gap_r;
    mode_d      = mode_r;
    gap_cnt_d   = gap_cnt;
    stop_pend_d = stop_pend;
    fc_d        = frame_cnt;
    data_d      = data_out;
    sof_d       = sof;
    eof_d       = eof;

    if (launch) begin
      kb_d        = kb_clamp;
      nf_d        = num_frames;
      gap_d       = gap;
      mode_d      = mode;
      lfsr_d      = SEED_EFF;
      cnt_d       = '0;
      idx_d       = 5'd0;
      fc_d        = 16'd0;
      stop_pend_d = 1'b0;
      gap_cnt_d   = 8'd0;
    end else if (load) begin
      data_d = mode_r ? cnt : prbs_bits(lfsr);
      lfsr_d = prbs_next(lfsr);
      cnt_d  = cnt + Z'(1);
      idx_d  = nidx;
      sof_d  = (nidx == 5'd0);
      eof_d  = (nidx == kb_r - 5'd1);
    end else begin
      data_d = data_out;
    end

    if (last_beat) begin
      fc_d = fc_inc;
    end else begin
      fc_d = fc_d;
    end

    if ((state == RUN) && (state_nxt == GAP)) begin
      gap_cnt_d = gap_r - 8'd1;
    end else if ((state == GAP) && (gap_cnt != 8'd0)) begin
      gap_cnt_d = gap_cnt - 8'd1;
    end else begin
      gap_cnt_d = gap_cnt_d;
    end

    if ((state == RUN) && stop && !run_end) begin
      stop_pend_d = 1'b1;
    end else begin
      stop_pend_d = stop_pend_d;
    end
  end

  // Datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr      <= SEED_EFF;
      cnt       <= '0;
      idx       <= 5'd0;
      kb_r      <= 5'd0;
      nf_r      <= 16'd0;
      gap_r     <= 8'd0;
      mode_r    <= 1'b0;
      gap_cnt   <= 8'd0;
      stop_pend <= 1'b0;
      frame_cnt <= 16'd0;
      data_out  <= '0;
      valid     <= 1'b0;
      sof       <= 1'b0;
      eof       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      lfsr      <= lfsr_d;
      cnt       <= cnt_d;
      idx       <= idx_d;
      kb_r      <= kb_d;
      nf_r      <= nf_d;
      gap_r     <= gap_d;
      mode_r    <= mode_d;
      gap_cnt   <= gap_cnt_d;
      stop_pend <= stop_pend_d;
      frame_cnt <= fc_d;
      data_out  <= data_d;
      valid     <= valid_d;
      sof       <= sof_d;
      eof       <= eof_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule
